// File: rtl/i2c_adc_target.sv
// I2C target emulating a four-register ADC at a fixed address.
// Handles pointer, config and threshold writes and snapshot-based 16-bit reads.
module i2c_adc_target #(
  parameter logic [6:0]  TARGET_ADDR  = 7'h48,
  parameter logic [15:0] CONFIG_RESET = 16'h8583
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scl_pin,
  inout  wire logic   sda_pin,
  input  logic [15:0] sample_data,
  input  logic        sample_valid,
  output logic [15:0] config_reg,
  output logic        config_wr,
  output logic        busy
);
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_BYTE,
    S_WR_ACK, S_RD_BYTE, S_RD_ACK, S_IGNORE
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  scl_sync_q, scl_sync_d;
  logic [2:0]  sda_sync_q, sda_sync_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [7:0]  msb_q, msb_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [15:0] conv_q, conv_d;
  logic [15:0] cfg_q, cfg_d;
  logic [15:0] lo_q, lo_d;
  logic [15:0] hi_q, hi_d;
  logic [15:0] snap_q, snap_d;
  logic        byte_sel_q, byte_sel_d;
  logic        rw_q, rw_d;
  logic        sda_oe_q, sda_oe_d;
  logic        busy_q, busy_d;
  logic        cfg_wr_q, cfg_wr_d;

  logic        scl_s, scl_h, sda_s, sda_h;
  logic        scl_rise, scl_fall, start_det, stop_det;
  logic [7:0]  rx_byte, nxt_byte;
  logic [15:0] reg_sel;

  // [0] first sync stage, [1] synchronized value, [2] history
  assign scl_sync_d = {scl_sync_q[1:0], scl_pin};
  assign sda_sync_d = {sda_sync_q[1:0], sda_pin};
  assign scl_s = scl_sync_q[1];
  assign scl_h = scl_sync_q[2];
  assign sda_s = sda_sync_q[1];
  assign sda_h = sda_sync_q[2];

  assign scl_rise  = scl_s & ~scl_h;
  assign scl_fall  = ~scl_s & scl_h;
  assign start_det = scl_s & scl_h & sda_h & ~sda_s;
  assign stop_det  = scl_s & scl_h & ~sda_h & sda_s;
  assign rx_byte   = {shreg_q[6:0], sda_s};
  assign nxt_byte  = byte_sel_q ? snap_q[15:8] : snap_q[7:0];

  always_comb begin
    reg_sel = conv_q;
    unique case (ptr_q)
      2'd0: reg_sel = conv_q;
      2'd1: reg_sel = cfg_q;
      2'd2: reg_sel = lo_q;
      2'd3: reg_sel = hi_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    msb_d      = msb_q;
    cnt_d      = cnt_q;
    byte_idx_d = byte_idx_q;
    ptr_d      = ptr_q;
    cfg_d      = cfg_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    snap_d     = snap_q;
    byte_sel_d = byte_sel_q;
    rw_d       = rw_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    cfg_wr_d   = 1'b0;
    conv_d     = sample_valid ? sample_data : conv_q;

    if (stop_det) begin
      state_d  = S_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      state_d  = S_ADDR;
      cnt_d    = 4'd0;
      sda_oe_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_ADDR: begin
          if (scl_rise) begin
            shreg_d = rx_byte;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              if (rx_byte[7:1] == TARGET_ADDR) begin
                state_d    = S_ADDR_ACK;
                busy_d     = 1'b1;
                rw_d       = rx_byte[0];
                byte_sel_d = 1'b0;
                if (rx_byte[0]) snap_d = reg_sel;
              end else begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
              end
            end
          end
        end
        S_ADDR_ACK: begin
          // first fall starts the ACK, second fall ends it
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else if (rw_q) begin
              state_d  = S_RD_BYTE;
              sda_oe_d = ~snap_q[15];
              shreg_d  = {snap_q[14:8], 1'b0};
              cnt_d    = 4'd1;
            end else begin
              state_d    = S_WR_BYTE;
              sda_oe_d   = 1'b0;
              cnt_d      = 4'd0;
              byte_idx_d = 2'd0;
            end
          end
        end
        S_WR_BYTE: begin
          if (scl_rise) begin
            shreg_d = rx_byte;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d   = 4'd0;
              state_d = S_WR_ACK;
              unique case (byte_idx_q)
                2'd0: ptr_d = rx_byte[1:0];
                2'd1: msb_d = rx_byte;
                2'd2: begin
                  unique case (ptr_q)
                    2'd0: ;
                    2'd1: begin
                      cfg_d    = {msb_q, rx_byte};
                      cfg_wr_d = 1'b1;
                    end
                    2'd2: lo_d = {msb_q, rx_byte};
                    2'd3: hi_d = {msb_q, rx_byte};
                  endcase
                end
                2'd3: state_d = S_IGNORE;
              endcase
            end
          end
        end
        S_WR_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d   = 1'b0;
              state_d    = S_WR_BYTE;
              cnt_d      = 4'd0;
              byte_idx_d = byte_idx_q + 2'd1;
            end
          end
        end
        S_RD_BYTE: begin
          if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              state_d  = S_RD_ACK;
              cnt_d    = 4'd0;
            end else begin
              sda_oe_d = ~shreg_q[7];
              shreg_d  = {shreg_q[6:0], 1'b0};
              cnt_d    = cnt_q + 4'd1;
            end
          end
        end
        S_RD_ACK: begin
          if (scl_rise) begin
            if (sda_s) begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
            end else begin
              cnt_d = 4'd1;
            end
          end else if (scl_fall && cnt_q == 4'd1) begin
            byte_sel_d = ~byte_sel_q;
            sda_oe_d   = ~nxt_byte[7];
            shreg_d    = {nxt_byte[6:0], 1'b0};
            state_d    = S_RD_BYTE;
          end
        end
        S_IGNORE: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      scl_sync_q <= 3'b111;
      sda_sync_q <= 3'b111;
      shreg_q    <= 8'h00;
      msb_q      <= 8'h00;
      cnt_q      <= 4'd0;
      byte_idx_q <= 2'd0;
      ptr_q      <= 2'd0;
      conv_q     <= 16'h0000;
      cfg_q      <= CONFIG_RESET;
      lo_q       <= 16'h8000;
      hi_q       <= 16'h7FFF;
      snap_q     <= 16'h0000;
      byte_sel_q <= 1'b0;
      rw_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      cfg_wr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      shreg_q    <= shreg_d;
      msb_q      <= msb_d;
      cnt_q      <= cnt_d;
      byte_idx_q <= byte_idx_d;
      ptr_q      <= ptr_d;
      conv_q     <= conv_d;
      cfg_q      <= cfg_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      snap_q     <= snap_d;
      byte_sel_q <= byte_sel_d;
      rw_q       <= rw_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      cfg_wr_q   <= cfg_wr_d;
    end
  end

  assign sda_pin    = sda_oe_q ? 1'b0 : 1'bz;
  assign config_reg = cfg_q;
  assign config_wr  = cfg_wr_q;
  assign busy       = busy_q;
endmodule

// File: tb/tb_i2c_adc_target.sv
// Directed bench for i2c_adc_target: a bit-banged controller on an
// open-drain bus, with hand-computed expected bytes and register values.
module tb_i2c_adc_target;
  localparam int Q = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m_scl = 1'b1;
  logic        m_sda = 1'b1;
  logic [15:0] sample_data = 16'h0000;
  logic        sample_valid = 1'b0;
  logic [15:0] config_reg;
  logic        config_wr;
  logic        busy;
  wire         sda;

  int n_cmp = 0;
  int n_err = 0;
  int wr_pulses = 0;

  assign sda = m_sda ? 1'bz : 1'b0;
  pullup (sda);

  i2c_adc_target dut (
    .clk          (clk),
    .reset        (reset),
    .scl_pin      (m_scl),
    .sda_pin      (sda),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .config_reg   (config_reg),
    .config_wr    (config_wr),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (config_wr) wr_pulses++;

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse_sample(input logic [15:0] d);
    @(negedge clk);
    sample_data  = d;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; wait_clk(Q);
    m_scl = 1'b1; wait_clk(Q);
    m_sda = 1'b0; wait_clk(Q);
    m_scl = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wait_clk(Q);
    m_scl = 1'b1; wait_clk(Q);
    m_sda = 1'b1; wait_clk(Q);
  endtask

  task automatic write_bit(input logic b);
    m_sda = b;    wait_clk(Q);
    m_scl = 1'b1; wait_clk(2 * Q);
    m_scl = 1'b0; wait_clk(Q);
  endtask

  task automatic read_bit(output logic b);
    m_sda = 1'b1; wait_clk(Q);
    m_scl = 1'b1; wait_clk(Q);
    b = sda;      wait_clk(Q);
    m_scl = 1'b0; wait_clk(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read8(output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    read8(d);
    write_bit(nack);
  endtask

  task automatic set_ptr(input logic [1:0] p, output logic [1:0] acks);
    logic a0, a1;
    i2c_start();
    write_byte(8'h90, a0);
    write_byte({6'd0, p}, a1);
    i2c_stop();
    acks = {a0, a1};
  endtask

  task automatic read2(output logic ack, output logic [15:0] v);
    logic [7:0] b0, b1;
    i2c_start();
    write_byte(8'h91, ack);
    read_byte(b0, 1'b0);
    read_byte(b1, 1'b1);
    i2c_stop();
    v = {b0, b1};
  endtask

  task automatic test_reset();
    wait_clk(4);
    reset = 1'b0;
    wait_clk(2);
    n_cmp++; if (config_reg !== 16'h8583) begin n_err++; $display("FAIL rst_config got %h want 8583", config_reg); end
    n_cmp++; if (config_wr !== 1'b0) begin n_err++; $display("FAIL rst_config_wr got %b want 0", config_wr); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
    n_cmp++; if (sda !== 1'b1) begin n_err++; $display("FAIL rst_sda got %b want 1", sda); end
  endtask

  task automatic test_config_write();
    logic a0, a1, a2, a3;
    int p0;
    p0 = wr_pulses;
    i2c_start();
    write_byte(8'h90, a0);
    write_byte(8'h01, a1);
    write_byte(8'h42, a2);
    write_byte(8'h43, a3);
    n_cmp++; if ({a0, a1, a2, a3} !== 4'b0000) begin n_err++; $display("FAIL cfg_acks got %b want 0000", {a0, a1, a2, a3}); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL cfg_busy_active got %b want 1", busy); end
    i2c_stop();
    n_cmp++; if (config_reg !== 16'h4243) begin n_err++; $display("FAIL cfg_value got %h want 4243", config_reg); end
    n_cmp++; if (wr_pulses - p0 !== 1) begin n_err++; $display("FAIL cfg_wr_pulses got %0d want 1", wr_pulses - p0); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL cfg_busy_after_stop got %b want 0", busy); end
  endtask

  task automatic test_read_conv();
    logic [1:0] pa;
    logic a;
    logic [7:0] b0, b1;
    pulse_sample(16'h1234);
    set_ptr(2'd0, pa);
    n_cmp++; if (pa !== 2'b00) begin n_err++; $display("FAIL conv_ptr_acks got %b want 00", pa); end
    i2c_start();
    write_byte(8'h91, a);
    read_byte(b0, 1'b0);
    read_byte(b1, 1'b1);
    wait_clk(6);
    n_cmp++; if (a !== 1'b0) begin n_err++; $display("FAIL conv_addr_ack got %b want 0", a); end
    n_cmp++; if ({b0, b1} !== 16'h1234) begin n_err++; $display("FAIL conv_data got %h want 1234", {b0, b1}); end
    n_cmp++; if (sda !== 1'b1) begin n_err++; $display("FAIL conv_sda_after_nack got %b want 1", sda); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL conv_busy_after_nack got %b want 0", busy); end
    i2c_stop();
  endtask

  task automatic test_wrong_addr();
    logic a, bz;
    i2c_start();
    write_byte(8'h92, a);
    bz = busy;
    i2c_stop();
    n_cmp++; if (a !== 1'b1) begin n_err++; $display("FAIL wrong_addr_ack got %b want 1", a); end
    n_cmp++; if (bz !== 1'b0) begin n_err++; $display("FAIL wrong_addr_busy got %b want 0", bz); end
    n_cmp++; if (config_reg !== 16'h4243) begin n_err++; $display("FAIL wrong_addr_config got %h want 4243", config_reg); end
  endtask

  task automatic test_mid_read_sample();
    logic a, a2;
    logic [7:0] b0, b1;
    logic [15:0] v;
    i2c_start();
    write_byte(8'h91, a);
    read8(b0);
    pulse_sample(16'hBEEF);
    write_bit(1'b0);
    read_byte(b1, 1'b1);
    i2c_stop();
    n_cmp++; if ({a, b0, b1} !== {1'b0, 16'h1234}) begin n_err++; $display("FAIL midread_first got %b/%h want 0/1234", a, {b0, b1}); end
    read2(a2, v);
    n_cmp++; if ({a2, v} !== {1'b0, 16'hBEEF}) begin n_err++; $display("FAIL midread_second got %b/%h want 0/beef", a2, v); end
  endtask

  task automatic test_thresholds();
    logic [1:0] pa;
    logic a, a0, a1, a2, a3, a4;
    logic [15:0] v;
    set_ptr(2'd2, pa);
    read2(a, v);
    n_cmp++; if ({pa, a, v} !== {3'b000, 16'h8000}) begin n_err++; $display("FAIL lo_thresh_reset got %b%b/%h want 000/8000", pa, a, v); end
    i2c_start();
    write_byte(8'h90, a0);
    write_byte(8'h03, a1);
    write_byte(8'h12, a2);
    write_byte(8'h34, a3);
    write_byte(8'h56, a4);
    i2c_stop();
    n_cmp++; if ({a0, a1, a2, a3, a4} !== 5'b00001) begin n_err++; $display("FAIL hi_write_acks got %b want 00001", {a0, a1, a2, a3, a4}); end
    read2(a, v);
    n_cmp++; if ({a, v} !== {1'b0, 16'h1234}) begin n_err++; $display("FAIL hi_thresh_read got %b/%h want 0/1234", a, v); end
    i2c_start();
    write_byte(8'h90, a0);
    write_byte(8'h00, a1);
    write_byte(8'h99, a2);
    write_byte(8'h99, a3);
    i2c_stop();
    read2(a, v);
    n_cmp++; if ({a0, a1, a2, a3, a, v} !== {5'b00000, 16'hBEEF}) begin n_err++; $display("FAIL conv_ro got %b/%h want 00000/beef", {a0, a1, a2, a3, a}, v); end
  endtask

  task automatic test_partial_write();
    logic a0, a1, a;
    logic [15:0] v;
    int p0;
    do_reset();
    p0 = wr_pulses;
    i2c_start();
    write_byte(8'h90, a0);
    write_byte(8'h01, a1);
    write_bit(1'b0);
    write_bit(1'b1);
    write_bit(1'b0);
    write_bit(1'b1);
    i2c_stop();
    n_cmp++; if (config_reg !== 16'h8583) begin n_err++; $display("FAIL partial_config got %h want 8583", config_reg); end
    n_cmp++; if (wr_pulses - p0 !== 0) begin n_err++; $display("FAIL partial_wr_pulses got %0d want 0", wr_pulses - p0); end
    read2(a, v);
    n_cmp++; if ({a0, a1, a, v} !== {3'b000, 16'h8583}) begin n_err++; $display("FAIL partial_readback got %b/%h want 000/8583", {a0, a1, a}, v); end
  endtask

  task automatic test_reset_mid_read();
    logic [1:0] pa;
    logic a0, a1, a2, a3, a, b;
    logic [15:0] v;
    i2c_start();
    write_byte(8'h90, a0);
    write_byte(8'h01, a1);
    write_byte(8'h11, a2);
    write_byte(8'h11, a3);
    i2c_stop();
    n_cmp++; if (config_reg !== 16'h1111) begin n_err++; $display("FAIL pre_reset_config got %h want 1111", config_reg); end
    pulse_sample(16'h1234);
    set_ptr(2'd0, pa);
    i2c_start();
    write_byte(8'h91, a);
    read_bit(b);
    n_cmp++; if ({pa, a, b} !== 4'b0000) begin n_err++; $display("FAIL midrst_first_bit got %b want 0000", {pa, a, b}); end
    n_cmp++; if ({sda, busy} !== 2'b01) begin n_err++; $display("FAIL midrst_driving got sda/busy %b want 01", {sda, busy}); end
    do_reset();
    n_cmp++; if (sda !== 1'b1) begin n_err++; $display("FAIL midrst_sda got %b want 1", sda); end
    n_cmp++; if ({busy, config_wr} !== 2'b00) begin n_err++; $display("FAIL midrst_flags got %b want 00", {busy, config_wr}); end
    n_cmp++; if (config_reg !== 16'h8583) begin n_err++; $display("FAIL midrst_config got %h want 8583", config_reg); end
    i2c_stop();
    i2c_start();
    write_byte(8'h90, a0);
    write_byte(8'h01, a1);
    write_byte(8'hAB, a2);
    write_byte(8'hCD, a3);
    i2c_stop();
    n_cmp++; if ({a0, a1, a2, a3, config_reg} !== {4'b0000, 16'hABCD}) begin n_err++; $display("FAIL after_rst_write got %b/%h want 0000/abcd", {a0, a1, a2, a3}, config_reg); end
    read2(a, v);
    n_cmp++; if ({a, v} !== {1'b0, 16'hABCD}) begin n_err++; $display("FAIL after_rst_read got %b/%h want 0/abcd", a, v); end
  endtask

  initial begin
    test_reset();
    test_config_write();
    test_read_conv();
    test_wrong_addr();
    test_mid_read_sample();
    test_thresholds();
    test_partial_write();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/i2c_adc_target.md
# i2c_adc_target

- Synthesizable I2C target (responder) modelling a four-register ADC at address 0x48.
- Serves the ADC read FSM over the same `scl_pin`/`sda_pin` bus: register-pointer writes, 16-bit config writes, and 16-bit conversion reads.
- Conversion data comes from a local `sample_data` port. Used as an on-chip ADC stand-in for closed-loop simulation and FPGA bring-up without the external converter.

## Interface
- `TARGET_ADDR`, default 7'h48: 7-bit address the block ACKs.
- `CONFIG_RESET`, default 16'h8583: reset value of the config register.
- `clk` input 1: system clock; must be ≥16× SCL frequency.
- `reset` input 1: synchronous, active-high reset.
- `scl_pin` input 1: I2C clock. The target never stretches SCL.
- `sda_pin` inout 1: I2C data. The block drives only 1'b0 or 1'bz.
- `sample_data` input 16: new conversion result.
- `sample_valid` input 1: one-cycle strobe that loads `sample_data`.
- `config_reg` output 16: current config register.
- `config_wr` output 1: one-cycle pulse when `config_reg` is updated.
- `busy` output 1: high from an addressed START to the end of the transaction.

## Operation
- Input conditioning: `scl_pin` and `sda_pin` each pass through a 2-flop synchronizer plus a history flop. Rise/fall strobes come from the synchronized values.
- START: SDA falls while SCL is high. Honoured in any state (repeated START included); bit counter clears, state goes to ADDR.
- STOP: SDA rises while SCL is high. From any state: go to IDLE, release SDA, clear `busy`.
- Registers, selected by a 2-bit pointer:
  - 0 = conversion, read-only.
  - 1 = config.
  - 2 = lo_thresh, reset 16'h8000.
  - 3 = hi_thresh, reset 16'h7FFF.
- Pointer resets to 0 and persists across transactions.
- SDA sampling and output timing:
  - Sample SDA on SCL rise.
  - Change driven SDA on SCL fall.
  - MSB first; 8-bit shift register; 4-bit bit counter.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits. On the 8th SCL rise:
    - addr == `TARGET_ADDR`: go to ADDR_ACK, set `busy`.
    - otherwise: go to IDLE with SDA released.
  - ADDR_ACK: drive SDA low from the next SCL fall through the following SCL fall.
    - R/W=0: go to WR_BYTE, byte index = 0.
    - R/W=1: snapshot the pointed register into the tx buffer, go to RD_BYTE.
  - WR_BYTE: shift 8 bits, then WR_ACK.
    - Byte 0 loads the pointer (bits [1:0]; bits [7:2] ignored).
    - Byte 1 is held as the MSB.
    - Byte 2 completes the LSB and commits {MSB, LSB} in the ACK cycle.
      - Pointer 0: write discarded, still ACKed.
      - Pointer 1: `config_wr` pulses for exactly one clk.
  - WR_ACK: ACK bytes 0–2. NACK (SDA released) byte 3 and later; after a NACK, ignore further bits until STOP/START.
  - RD_BYTE: drive tx buffer MSB-first: 0 bit → drive low, 1 bit → release. After 8 bits, release SDA and go to RD_ACK.
  - RD_ACK: sample the controller's bit on SCL rise.
    - ACK (0): send the next byte. Order is MSB, LSB, MSB, …; the same snapshot wraps.
    - NACK (1): go to IDLE, SDA released.
- Conversion register: loaded by `sample_valid` at any time, including mid-read.
  - An in-flight read returns the ADDR_ACK snapshot.
  - The new value appears on the next read.
- A partial write (fewer than 3 bytes) aborted by STOP/START commits nothing. A pointer byte already ACKed stays written.

## Timing
- Pin-to-action latency is 3 clk (2 sync + edge). SDA output changes 3–4 clk after the SCL fall at the pin.
- Reset values: SDA released (z), `config_reg` = `CONFIG_RESET`, `config_wr` = 0, `busy` = 0, pointer = 0, conversion = 0, thresholds as above, state IDLE.
- Reset asserted mid-transaction: SDA released and all of the above restored on the first clk edge with `reset` high. The bus is then ignored until the next START.
- `config_wr` asserts on the clk where the LSB ACK is decided (8th SCL rise of byte 2, +3 clk) and deasserts on the next clk.
- `busy` rises with the ADDR_ACK entry. It falls on the STOP detection clk, or on the IDLE entry after a read NACK.
- `sample_valid` and a register commit in the same clk do not interact: they target different registers.

## Test plan
- Write 0x90, 0x01, 0x42, 0x43, STOP → ACK on all four bytes; `config_reg` = 16'h4243; one `config_wr` pulse; `busy` low after STOP.
- `sample_valid` with 16'h1234; write 0x90, 0x00, STOP; read 0x91 with two bytes (ACK then NACK) → returns 0x12, 0x34; SDA released after NACK.
- Address 0x92 (0x49 W) → no ACK (SDA z on 9th clock); `busy` stays 0; `config_reg` unchanged.
- Read 0x91 while `sample_valid` loads 16'hBEEF between the bytes; prior value 16'h1234 → bytes 0x12, 0x34; a second read returns 0xBE, 0xEF.
- Write 0x90, 0x01, 0x55, then STOP mid-LSB → `config_reg` keeps 16'h8583; no `config_wr`; pointer = 1, so the next read returns 0x85, 0x83.
- Assert `reset` during RD_BYTE with SDA driven low → SDA z the next clk; all outputs at reset values; the following transaction completes normally.
